bk_bus_ctrl: RTL

Parametrised Q-bus cycle controller and vectored interrupt arbiter for the BK core. It sits between the vm1 CPU bus signals and the memory/peripheral fabric. It generates RPLY for internal register-space cycles with programmable wait states, and a bus-error on timeout or illegal access. It also arbitrates N level-sensitive interrupt channels into a single VIRQ, with per-channel vectors delivered on IAKO cycles.

---
 rtl/bk_bus_pkg.sv | 30 +++
 rtl/bk_irq_arbiter.sv | 58 +++++
 rtl/bk_bus_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bk_bus_pkg.sv
// Shared types and constants for the BK Q-bus cycle controller.
// The optional bus timeout is enabled with BK_BUS_TIMEOUT_EN.
package bk_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT,
    ST_REPLY,
    ST_ERROR
  } bus_state_e;

  // adrs[15:7] value that selects the on-chip register page
  localparam logic [8:0]  ADR_REG_BASE = 9'o777;

  localparam logic [15:0] ADR_177660 = 16'o177660;
  localparam logic [15:0] ADR_177662 = 16'o177662;
  localparam logic [15:0] ADR_177664 = 16'o177664;
  localparam logic [15:0] ADR_177714 = 16'o177714;
  localparam logic [15:0] ADR_177716 = 16'o177716;

  localparam logic [15:0] VEC_DEFAULT = 16'o060;
  localparam logic [15:0] VEC_0274    = 16'o0274;

  function automatic logic is_reg_space(input logic [15:0] adrs,
                                        input logic [8:0]  base);
    return adrs[15:7] == base;
  endfunction

endpackage

// File: rtl/bk_irq_arbiter.sv
// Masked fixed-priority interrupt encoder (lowest channel wins) with
// vector lookup and a registered VIRQ gated by CPU priority.
module bk_irq_arbiter
  import bk_bus_pkg::*;
#(
  parameter int               NCH       = 4,
  parameter logic [NCH*16-1:0] VEC_TABLE = {NCH{VEC_DEFAULT}},
  parameter int               IRQ_LEVEL = 1
) (
  input  logic           m_clock,
  input  logic           p_reset,
  input  logic           ce,
  input  logic [NCH-1:0] irq_req,
  input  logic [NCH-1:0] irq_en,
  input  logic [2:0]     psw_pri,
  output logic           win_valid,
  output logic [2:0]     win_idx,
  output logic [15:0]    win_vec,
  output logic           virq_o
);

  localparam logic [3:0] PRI_LIMIT = 4'(IRQ_LEVEL);

  logic [NCH-1:0] active;
  logic           virq_d;
  logic           virq_q;

  // NOTE: every output gets a default before the loop so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    active    = irq_req & irq_en;
    win_valid = 1'b0;
    win_idx   = '0;
    win_vec   = '0;
    // Scan downward so the lowest active channel is the last to write.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (active[i]) begin
        win_valid = 1'b1;
        win_idx   = 3'(i);
        win_vec   = VEC_TABLE[16*i +: 16];
      end
    end
    virq_d = win_valid & ({1'b0, psw_pri} < PRI_LIMIT);
  end

  // NOTE: state registers use non-blocking assignments so all flops
  // sample the same pre-edge values regardless of process order.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      virq_q <= 1'b0;
    end else if (ce) begin
      virq_q <= virq_d;
    end
  end

  assign virq_o = virq_q;

endmodule

// File: rtl/bk_bus_ctrl.sv
// Q-bus cycle controller: register-space RPLY with wait states, bus error on
// ROM writes (and on timeout when BK_BUS_TIMEOUT_EN is defined), IAKO vectors.
module bk_bus_ctrl
  import bk_bus_pkg::*;
#(
  parameter int                NCH       = 4,
  parameter logic [NCH*16-1:0] VEC_TABLE = {NCH{VEC_DEFAULT}},
  parameter logic [8:0]        REG_BASE  = ADR_REG_BASE,
  parameter int                REG_WAIT  = 1,
  parameter int                TIMEOUT   = 63,
  parameter int                IRQ_LEVEL = 1
) (
  input  logic           m_clock,
  input  logic           p_reset,
  input  logic           ce,
  input  logic           cpu_sync,
  input  logic           cpu_din,
  input  logic           cpu_dout,
  input  logic           cpu_iako,
  input  logic [15:0]    cpu_adrs,
  input  logic           rom_wr,
  input  logic           dev_rply,
  input  logic [NCH-1:0] irq_req,
  input  logic [NCH-1:0] irq_en,
  input  logic [2:0]     psw_pri,
  output logic           reg_sel,
  output logic           rply_o,
  output logic           error_o,
  output logic           virq_o,
  output logic [15:0]    vector_o,
  output logic [NCH-1:0] irq_ack
);

  if (NCH < 1 || NCH > 8) begin : g_bad_nch
    $error("bk_bus_ctrl: NCH must be 1..8");
  end
  if (REG_WAIT < 0 || REG_WAIT > 15) begin : g_bad_wait
    $error("bk_bus_ctrl: REG_WAIT must be 0..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("bk_bus_ctrl: TIMEOUT must be 1..255");
  end

  bus_state_e     state_q, state_d;
  logic           sync_q, sync_d;
  logic           sync_dly_q, sync_dly_d;
  logic           reg_sel_q, reg_sel_d;
  logic           iako_q, iako_d;
  logic           rom_q, rom_d;
  logic [3:0]     wait_cnt_q, wait_cnt_d;
  logic           rply_q, rply_d;
  logic           error_q, error_d;
  logic [15:0]    vec_q, vec_d;
  logic [NCH-1:0] ack_q, ack_d;

  logic           sync_rise;
  logic           ext_rply;
  logic           to_hit;
  logic           win_valid;
  logic [2:0]     win_idx;
  logic [15:0]    win_vec;

  // Strobe qualifiers and the low address bits do not affect cycle control.
  logic unused_bits;
  assign unused_bits = ^{cpu_din, cpu_dout, cpu_adrs[6:0]};

  bk_irq_arbiter #(
    .NCH       (NCH),
    .VEC_TABLE (VEC_TABLE),
    .IRQ_LEVEL (IRQ_LEVEL)
  ) u_arb (
    .m_clock   (m_clock),
    .p_reset   (p_reset),
    .ce        (ce),
    .irq_req   (irq_req),
    .irq_en    (irq_en),
    .psw_pri   (psw_pri),
    .win_valid (win_valid),
    .win_idx   (win_idx),
    .win_vec   (win_vec),
    .virq_o    (virq_o)
  );

  // External cycles reply straight from the device while waiting.
  assign ext_rply  = (state_q == ST_WAIT) && !reg_sel_q && dev_rply;
  assign sync_rise = sync_q & ~sync_dly_q;

`ifdef BK_BUS_TIMEOUT_EN
  logic [7:0] to_cnt_q, to_cnt_d;

  // Counts ce ticks since the cycle was picked up; frozen while replying.
  always_comb begin
    to_cnt_d = to_cnt_q;
    to_hit   = 1'b0;
    case (state_q)
      ST_IDLE:   to_cnt_d = (sync_rise && cpu_sync) ? 8'd1 : 8'd0;
      ST_DECODE: to_cnt_d = to_cnt_q + 8'd1;
      ST_WAIT: begin
        if (!ext_rply) begin
          to_cnt_d = to_cnt_q + 8'd1;
          to_hit   = ({1'b0, to_cnt_q} + 9'd1) >= 9'(TIMEOUT);
        end
      end
      default: to_cnt_d = to_cnt_q;
    endcase
    if (state_q != ST_IDLE && !cpu_sync) to_cnt_d = 8'd0;
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      to_cnt_q <= 8'd0;
    end else if (ce) begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    sync_d     = cpu_sync;
    sync_dly_d = sync_q;
    reg_sel_d  = reg_sel_q;
    iako_d     = iako_q;
    rom_d      = rom_q;
    wait_cnt_d = wait_cnt_q;
    vec_d      = vec_q;
    ack_d      = '0;

    if (state_q != ST_IDLE && !cpu_sync) begin
      state_d    = ST_IDLE;
      reg_sel_d  = 1'b0;
      iako_d     = 1'b0;
      rom_d      = 1'b0;
      wait_cnt_d = 4'd0;
      vec_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sync_rise && cpu_sync) begin
            state_d   = ST_DECODE;
            reg_sel_d = is_reg_space(cpu_adrs, REG_BASE);
            iako_d    = cpu_iako;
            rom_d     = rom_wr;
          end
        end
        ST_DECODE: begin
          if (rom_q) begin
            state_d = ST_ERROR;
          end else if (iako_q) begin
            // Winner is frozen here; later request changes do not matter.
            state_d = ST_REPLY;
            vec_d   = win_valid ? win_vec : 16'd0;
            ack_d   = win_valid ? (NCH'(1) << win_idx) : '0;
          end else if (reg_sel_q) begin
            wait_cnt_d = 4'(REG_WAIT);
            state_d    = (REG_WAIT == 0) ? ST_REPLY : ST_WAIT;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (reg_sel_q) begin
            wait_cnt_d = wait_cnt_q - 4'd1;
            if (wait_cnt_q <= 4'd1) state_d = ST_REPLY;
          end
          // A reply on the same tick as expiry takes precedence.
          if (state_d == ST_WAIT && to_hit) state_d = ST_ERROR;
        end
        default: state_d = state_q;
      endcase
    end

    rply_d  = (state_d == ST_REPLY);
    error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      state_q    <= ST_IDLE;
      // Treat SYNC as already high so a cycle in flight at release is skipped.
      sync_q     <= 1'b1;
      sync_dly_q <= 1'b1;
      reg_sel_q  <= 1'b0;
      iako_q     <= 1'b0;
      rom_q      <= 1'b0;
      wait_cnt_q <= 4'd0;
      rply_q     <= 1'b0;
      error_q    <= 1'b0;
      vec_q      <= '0;
      ack_q      <= '0;
    end else if (ce) begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      sync_dly_q <= sync_dly_d;
      reg_sel_q  <= reg_sel_d;
      iako_q     <= iako_d;
      rom_q      <= rom_d;
      wait_cnt_q <= wait_cnt_d;
      rply_q     <= rply_d;
      error_q    <= error_d;
      vec_q      <= vec_d;
      ack_q      <= ack_d;
    end
  end

  assign reg_sel  = reg_sel_q;
  assign rply_o   = rply_q | ext_rply;
  assign error_o  = error_q;
  assign vector_o = vec_q;
  assign irq_ack  = ack_q;

endmodule
